// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

endpackage

// File: rtl/updown_next.sv
// Combinational next-count and boundary-flag unit for the up/down modulo counter.
module updown_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 1
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              down,
  input  cnt_mode_t         mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  nxt,
  output logic              bnd
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  // One extra bit keeps sums and modulus (limit+1) exact.
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] mod_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] wrap_up_x;
  logic [WIDTH:0] wrap_dn_x;

  assign cur_x     = {1'b0, cur};
  assign lim_x     = {1'b0, limit};
  assign mod_x     = lim_x + ONE;
  assign inc_x     = (WIDTH + 1)'(step) + ONE;
  assign sum_x     = cur_x + inc_x;
  assign wrap_up_x = sum_x - mod_x;
  // A negative result wraps to a huge value and is caught by the > limit test.
  assign wrap_dn_x = cur_x + mod_x - inc_x;

  always_comb begin
    nxt = cur;
    bnd = 1'b0;
    if (cur_x > lim_x) begin
      nxt = down ? limit : '0;
      bnd = 1'b1;
    end else if (!down) begin
      if (sum_x <= lim_x) begin
        nxt = cur + inc_x[WIDTH-1:0];
      end else begin
        bnd = 1'b1;
        if (mode == CNT_SAT)        nxt = limit;
        else if (wrap_up_x > lim_x) nxt = '0;
        else                        nxt = wrap_up_x[WIDTH-1:0];
      end
    end else begin
      if (cur_x >= inc_x) begin
        nxt = cur - inc_x[WIDTH-1:0];
      end else begin
        bnd = 1'b1;
        if (mode == CNT_SAT)        nxt = '0;
        else if (wrap_dn_x > lim_x) nxt = limit;
        else                        nxt = wrap_dn_x[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate boundary and synchronous load.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  input  logic              down,
  input  cnt_mode_t         mode,
  input  logic              ld,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  out,
  output logic              tc
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic             tc_reg;
  logic             tc_next;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_bnd;

  updown_next #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) u_next (
    .cur  (out_reg),
    .step (step),
    .down (down),
    .mode (mode),
    .limit(limit),
    .nxt  (cnt_nxt),
    .bnd  (cnt_bnd)
  );

  // Load beats count; loaded values are clamped into 0..limit.
  always_comb begin
    out_next = out_reg;
    tc_next  = 1'b0;
    if (ld) begin
      out_next = (din > limit) ? limit : din;
    end else if (en) begin
      out_next = cnt_nxt;
      tc_next  = cnt_bnd;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_reg <= '0;
      tc_reg  <= 1'b0;
    end else begin
      out_reg <= out_next;
      tc_reg  <= tc_next;
    end
  end

  assign out = out_reg;
  assign tc  = tc_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized and directed check of updown_mod_counter against an arithmetic reference model.
module tb_updown_mod_counter;
  import counter_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 1;

  logic              clk;
  logic              nrst;
  logic              en;
  logic [STEP_W-1:0] step;
  logic              down;
  cnt_mode_t         mode;
  logic              ld;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  out;
  logic              tc;

  int vec_cnt;
  int err_cnt;
  int m_out;
  int m_tc;

  updown_mod_counter #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .step (step),
    .down (down),
    .mode (mode),
    .ld   (ld),
    .din  (din),
    .limit(limit),
    .out  (out),
    .tc   (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the counting rules.
  task automatic model_step(input int l, input int e, input int s, input int d,
                            input int md, input int di, input int lim);
    int inc;
    int r;
    inc = s + 1;
    if (l != 0) begin
      m_out = (di < lim) ? di : lim;
      m_tc  = 0;
    end else if (e == 0) begin
      m_tc = 0;
    end else begin
      m_tc = 1;
      if (m_out > lim) begin
        m_out = (d != 0) ? lim : 0;
      end else if (d == 0) begin
        if (m_out + inc <= lim) begin
          m_out = m_out + inc;
          m_tc  = 0;
        end else if (md != 0) begin
          m_out = lim;
        end else begin
          r     = m_out + inc - (lim + 1);
          m_out = (r > lim) ? 0 : r;
        end
      end else begin
        if (m_out >= inc) begin
          m_out = m_out - inc;
          m_tc  = 0;
        end else if (md != 0) begin
          m_out = 0;
        end else begin
          r     = m_out + lim + 1 - inc;
          m_out = (r < 0 || r > lim) ? lim : r;
        end
      end
    end
  endtask

  // One clocked transaction; eo/et >= 0 are also checked as literal expectations.
  task automatic cyc(input int l, input int e, input int s, input int d, input int md,
                     input int di, input int lim, input int eo, input int et);
    ld    = l[0];
    en    = e[0];
    step  = s[STEP_W-1:0];
    down  = d[0];
    mode  = cnt_mode_t'(md[0]);
    din   = di[WIDTH-1:0];
    limit = lim[WIDTH-1:0];
    @(posedge clk);
    model_step(l, e, s, d, md, di, lim);
    #1;
    $display("txn ld=%0d en=%0d step=%0d down=%0d mode=%0d din=%0d limit=%0d -> out=%0d tc=%0d",
             l, e, s, d, md, di, lim, out, tc);
    check_val("out", int'(out), m_out);
    check_val("tc", int'(tc), m_tc);
    if (eo >= 0) check_val("out_lit", int'(out), eo);
    if (et >= 0) check_val("tc_lit", int'(tc), et);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    m_out   = 0;
    m_tc    = 0;
    nrst    = 1'b0;
    en      = 1'b0;
    ld      = 1'b0;
    step    = '0;
    down    = 1'b0;
    mode    = CNT_WRAP;
    din     = '0;
    limit   = '0;
    #12;
    check_val("rst_out", int'(out), 0);
    check_val("rst_tc", int'(tc), 0);
    nrst = 1'b1;

    // Reset mid-count: count to 5, then assert reset between edges.
    cyc(1, 0, 0, 0, 0, 3, 15, 3, 0);
    cyc(0, 1, 1, 0, 0, 0, 15, 5, 0);
    #2;
    nrst = 1'b0;
    #1;
    m_out = 0;
    m_tc  = 0;
    check_val("async_rst_out", int'(out), 0);
    check_val("async_rst_tc", int'(tc), 0);
    ld = 1'b1;
    en = 1'b1;
    din = 4'd9;
    @(posedge clk);
    #1;
    check_val("rst_hold_out", int'(out), 0);
    #3;
    nrst = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 15, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 15, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 15, 2, 0);

    // Up wrap.
    cyc(1, 0, 1, 0, 0, 8, 9, 8, 0);
    cyc(0, 1, 1, 0, 0, 0, 9, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 9, 2, 0);
    cyc(0, 1, 1, 0, 0, 0, 9, 4, 0);

    // Down wrap.
    cyc(1, 0, 0, 1, 0, 0, 15, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 15, 15, 1);
    cyc(0, 1, 0, 1, 0, 0, 15, 14, 0);
    cyc(1, 0, 1, 1, 0, 0, 2, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 2, 1, 1);

    // Saturation, repeated boundary keeps tc high.
    cyc(1, 0, 1, 0, 1, 11, 12, 11, 0);
    cyc(0, 1, 1, 0, 1, 0, 12, 12, 1);
    cyc(0, 1, 1, 0, 1, 0, 12, 12, 1);
    cyc(1, 0, 1, 1, 1, 1, 12, 1, 0);
    cyc(0, 1, 1, 1, 1, 0, 12, 0, 1);

    // Load priority and clamping.
    cyc(1, 1, 1, 0, 0, 14, 9, 9, 0);
    cyc(1, 0, 1, 0, 0, 3, 9, 3, 0);

    // Limit lowered below the count, then hold.
    cyc(1, 0, 1, 0, 0, 12, 15, 12, 0);
    cyc(0, 1, 1, 0, 0, 0, 7, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 7, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 7, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 7, 0, 0);

    // Limit lowered with down count goes to limit; limit 0 always lands on 0.
    cyc(1, 0, 0, 0, 0, 13, 15, 13, 0);
    cyc(0, 1, 0, 1, 1, 0, 6, 6, 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 1);

    // Randomized traffic against the model.
    begin
      int lim_r;
      lim_r = 9;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(15) == 0) lim_r = int'($urandom_range(15));
        cyc(($urandom_range(7) == 0) ? 1 : 0,
            ($urandom_range(3) != 0) ? 1 : 0,
            int'($urandom_range(1)),
            int'($urandom_range(1)),
            int'($urandom_range(1)),
            int'($urandom_range(15)),
            lim_r, -1, -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
